qm_mem_arbiter: RTL

Two-port read arbiter that shares the single memory-controller command/read-FIFO port between the instruction cache (port 0) and the data cache (port 1). It accepts cache-line refill requests, picks one with round-robin fairness, and issues one aligned read burst for the winner. It then steers returned words to the winner only. It sits between the caches and the memory controller, replacing direct cache-to-controller wiring.

---
 rtl/qm_mem_pkg.sv | 32 +++
 rtl/qm_rr_arb2.sv | 24 ++
 rtl/qm_mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/qm_mem_pkg.sv
`default_nettype none
// =============================================================================
// Module   : qm_mem_pkg
// Purpose  : Shared types, command encodings and burst helpers for the
//            cache refill arbiter.
// Revision : 1.0
// =============================================================================
package qm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [2:0] MEM_CMD_READ = 3'b001;

    function automatic logic [5:0] burst_bl(input int unsigned words);
        return 6'(words - 1);
    endfunction

    // Number of low byte-address bits cleared to align a burst.
    function automatic int unsigned align_shift(input int unsigned words);
        return $clog2(words * 4);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qm_rr_arb2.sv
`default_nettype none
// =============================================================================
// Module   : qm_rr_arb2
// Purpose  : Combinational two-way round-robin picker with one-hot grant.
// Revision : 1.0
// =============================================================================
module qm_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            // On a tie the port that was not served last wins.
            o_gnt = i_last_served ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qm_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : qm_mem_arbiter
// Purpose  : Shares one memory-controller read port between the I-cache
//            (port 0) and D-cache (port 1), one aligned burst per grant.
// Revision : 1.0
// =============================================================================
module qm_mem_arbiter
    import qm_mem_pkg::*;
#(
    parameter int unsigned BURST_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        rq0_req,
    input  logic [29:0] rq0_addr,
    output logic        rq0_gnt,
    output logic [31:0] rq0_data,
    output logic        rq0_valid,
    output logic        rq0_done,

    input  logic        rq1_req,
    input  logic [29:0] rq1_addr,
    output logic        rq1_gnt,
    output logic [31:0] rq1_data,
    output logic        rq1_valid,
    output logic        rq1_done,

    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_addr,
    input  logic        mem_cmd_full,

    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_empty
);

    localparam int unsigned     c_SHIFT      = align_shift(BURST_WORDS);
    localparam int unsigned     c_CW         = cnt_width(BURST_WORDS);
    localparam logic [c_CW-1:0] c_LAST       = c_CW'(BURST_WORDS - 1);
    localparam logic [5:0]      c_BL         = burst_bl(BURST_WORDS);
    localparam logic [29:0]     c_ALIGN_MASK = ~30'((32'd1 << c_SHIFT) - 32'd1);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_last;
    logic [c_CW-1:0]   r_cnt;
    logic [29:0]       r_addr;
    logic [1:0]        r_gnt;

    arb_state_t        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_last_nxt;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic [29:0]       w_addr_nxt;
    logic [1:0]        w_gnt_nxt;
    logic [1:0]        w_pick;
    logic              w_cmd_en;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_done;
    logic [31:0]       w_rd_data;

    qm_rr_arb2 u_rr_arb2 (
        .i_req         ({rq1_req, rq0_req}),
        .i_last_served (r_last),
        .o_gnt         (w_pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_gnt   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_cmd_en    = 1'b0;
        w_rd_en     = 1'b0;
        w_pop       = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (|w_pick) begin
                    w_owner_nxt = w_pick[1] & ~w_pick[0];
                    w_addr_nxt  = (w_pick[1] ? rq1_addr : rq0_addr) & c_ALIGN_MASK;
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                w_cmd_en = !mem_cmd_full;
                if (!mem_cmd_full) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_rd_en = 1'b1;
                w_pop   = !mem_rd_empty;
                if (w_pop) begin
                    if (r_cnt == c_LAST) begin
                        w_done      = 1'b1;
                        w_last_nxt  = r_owner;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Grant is registered from the post-edge state so it rises with the command cycle.
        w_gnt_nxt[0] = (w_state_nxt != IDLE) && !w_owner_nxt;
        w_gnt_nxt[1] = (w_state_nxt != IDLE) &&  w_owner_nxt;
    end

    assign w_rd_data = (r_state == DATA) ? mem_rd_data : 32'd0;

    assign rq0_gnt   = r_gnt[0];
    assign rq1_gnt   = r_gnt[1];
    assign rq0_data  = w_rd_data;
    assign rq1_data  = w_rd_data;
    assign rq0_valid = w_pop && !r_owner;
    assign rq1_valid = w_pop &&  r_owner;
    assign rq0_done  = w_done && !r_owner;
    assign rq1_done  = w_done &&  r_owner;

    assign mem_cmd_en    = w_cmd_en;
    assign mem_cmd_instr = MEM_CMD_READ;
    assign mem_cmd_bl    = c_BL;
    assign mem_cmd_addr  = r_addr;
    assign mem_rd_en     = w_rd_en;

endmodule
`default_nettype wire
